// File: rtl/uart_host_seq.sv
// uart_host_seq: host-side UART loader command sequencer (tx frames, rx reply collection)
module uart_host_seq #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_vld_i,
  output logic            req_rdy_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_len_i,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_data_vld_i,
  output logic            wr_data_rdy_o,
  output logic [7:0]      rd_data_o,
  output logic            rd_data_vld_o,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_data_vld_o,
  input  logic            uart_tx_data_rdy_i,
  input  logic [7:0]      uart_rx_data_i,
  input  logic            uart_rx_data_vld_i,
  output logic            uart_rx_data_rdy_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_CFG, S_WDATA, S_RDATA, S_DONE} state_e;
  state_e          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] addr_q, len_q, cfg_len_q, cnt_q, tmo_q;
  logic [3:0]      idx_q;
  logic [7:0]      tx_data_q, rd_data_q;
  logic            tx_vld_q, rd_vld_q, req_rdy_q, busy_q, done_q, err_q;
  logic            accept, bad_req, tx_xfer, wr_take, fin_ok, fin_err;
  logic [63:0]     cfg_frame;
  assign req_rdy_o          = req_rdy_q;
  assign wr_data_rdy_o      = wr_take;
  assign rd_data_o          = rd_data_q;
  assign rd_data_vld_o      = rd_vld_q;
  assign uart_tx_data_o     = tx_data_q;
  assign uart_tx_data_vld_o = tx_vld_q;
  assign uart_rx_data_rdy_o = 1'b1;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign err_o              = err_q;
  // handshake decodes and end-of-transaction detection (a late rx byte beats the timeout)
  always_comb begin
    accept    = state_q == S_IDLE && req_vld_i && req_rdy_q;
    bad_req   = req_op_i > 3'd5 || (req_op_i == 3'd2 && req_len_i == '0);
    tx_xfer   = tx_vld_q && uart_tx_data_rdy_i;
    wr_take   = state_q == S_WDATA && !tx_vld_q && uart_tx_data_rdy_i && cnt_q != '0;
    cfg_frame = {32'(len_q - 1'b1), 32'(addr_q)};
    fin_ok    = (state_q == S_CMD && tx_xfer && op_q < 3'd2) ||
                (state_q == S_CFG && tx_xfer && idx_q == 4'd8) ||
                (state_q == S_WDATA && tx_xfer && cnt_q == '0) ||
                (state_q == S_RDATA && uart_rx_data_vld_i && cnt_q == XLEN'(1));
    fin_err   = (accept && bad_req) ||
                (state_q == S_RDATA && !uart_rx_data_vld_i && tmo_q == XLEN'(TIMEOUT - 1));
  end
  // sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cfg_len_q <= XLEN'(1);
      cnt_q     <= '0;
      tmo_q     <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      req_rdy_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rd_vld_q <= 1'b0;
      done_q   <= fin_ok || fin_err;
      err_q    <= fin_err;
      if (tx_xfer) tx_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          op_q      <= req_op_i;
          addr_q    <= req_addr_i;
          len_q     <= req_len_i;
          req_rdy_q <= 1'b0;
          idx_q     <= '0;
          tmo_q     <= '0;
          if (!bad_req) begin
            busy_q    <= 1'b1;
            tx_vld_q  <= 1'b1;
            tx_data_q <= 8'h2a + 8'(req_op_i);
            state_q   <= S_CMD;
          end
        end
        S_CMD: if (tx_xfer) begin
          cnt_q <= op_q == 3'd3 ? XLEN'(8) : cfg_len_q;
          if (op_q == 3'd2) state_q <= S_CFG;
          else if (op_q == 3'd4) state_q <= S_WDATA;
          else if (op_q == 3'd3 || op_q == 3'd5) state_q <= S_RDATA;
        end
        S_CFG: begin
          if (!tx_vld_q && uart_tx_data_rdy_i && idx_q != 4'd8) begin
            tx_vld_q  <= 1'b1;
            tx_data_q <= cfg_frame[{idx_q[2:0], 3'b000} +: 8];
            idx_q     <= idx_q + 4'd1;
          end
          if (fin_ok) cfg_len_q <= len_q;
        end
        S_WDATA: if (wr_take && wr_data_vld_i) begin
          tx_vld_q  <= 1'b1;
          tx_data_q <= wr_data_i;
          cnt_q     <= cnt_q - 1'b1;
        end
        S_RDATA: if (uart_rx_data_vld_i) begin
          rd_data_q <= uart_rx_data_i;
          rd_vld_q  <= 1'b1;
          cnt_q     <= cnt_q - 1'b1;
          tmo_q     <= '0;
        end else tmo_q <= tmo_q + 1'b1;
        S_DONE: begin
          req_rdy_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (fin_ok || fin_err) begin
        busy_q  <= 1'b0;
        state_q <= S_DONE;
      end
    end
  end
endmodule

// File: tb/tb_uart_host_seq.sv
// tb_uart_host_seq: table-driven directed bench for uart_host_seq
module tb_uart_host_seq;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_vld = 1'b0, req_rdy;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_len = '0;
  logic [7:0]  wr_data;
  logic        wr_vld, wr_rdy;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic [7:0]  tx_data;
  logic        tx_vld, tx_rdy;
  logic [7:0]  rx_data = '0;
  logic        rx_vld = 1'b0, rx_rdy;
  logic        busy, done, err;
  always #5 clk = ~clk;

  uart_host_seq #(.XLEN(32), .TIMEOUT(50)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_op_i(req_op), .req_addr_i(req_addr), .req_len_i(req_len),
    .wr_data_i(wr_data), .wr_data_vld_i(wr_vld), .wr_data_rdy_o(wr_rdy),
    .rd_data_o(rd_data), .rd_data_vld_o(rd_vld),
    .uart_tx_data_o(tx_data), .uart_tx_data_vld_o(tx_vld), .uart_tx_data_rdy_i(tx_rdy),
    .uart_rx_data_i(rx_data), .uart_rx_data_vld_i(rx_vld), .uart_rx_data_rdy_o(rx_rdy),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] len;
    int          n;
    logic [71:0] b;
    logic        e;
  } vec_t;

  int         n_cmp = 0, n_bad = 0, cyc = 0, last_rd_cyc = 0, done_cyc = 0;
  int         wr_i = 0, wr_n = 0;
  logic [7:0] txq[$], rdq[$];
  logic [7:0] pay[12] = '{8'h93, 8'h05, 8'h00, 8'h00, 8'h6f, 8'h00, 8'h50, 8'h00, 8'h93, 8'h85, 8'h15, 8'h00};
  logic [7:0] rx_bytes[8];
  logic       got_done, got_err, rdy_at, rdy_nxt;
  vec_t       v[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [2:0] op, logic [31:0] a, logic [31:0] l, int n, logic [71:0] b, logic e);
    vec_t r;
    r.op = op; r.addr = a; r.len = l; r.n = n; r.b = b; r.e = e;
    return r;
  endfunction

  // uart_tx model: logs each transfer, then goes busy for two cycles
  initial begin
    int gap;
    bit x;
    gap = 0;
    tx_rdy = 1'b1;
    forever begin
      @(negedge clk);
      x = tx_vld && tx_rdy;
      if (x) txq.push_back(tx_data);
      @(posedge clk);
      #1;
      if (x) begin
        gap = 2;
        tx_rdy = 1'b0;
      end else if (gap > 0) begin
        gap--;
        tx_rdy = (gap == 0);
      end
    end
  end

  // reply byte monitor
  initial forever begin
    @(negedge clk);
    if (rd_vld) begin
      rdq.push_back(rd_data);
      last_rd_cyc = cyc;
    end
  end

  // payload source with randomly toggled valid
  initial begin
    bit t;
    wr_vld = 1'b0;
    wr_data = '0;
    forever begin
      @(negedge clk);
      t = wr_vld && wr_rdy;
      if (t) wr_i++;
      @(posedge clk);
      #1;
      wr_vld = wr_i < wr_n && $urandom_range(0, 1) == 1;
      wr_data = wr_i < wr_n ? pay[wr_i] : 8'h00;
    end
  end

  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] len);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    req_op = op; req_addr = addr; req_len = len; req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    got_done = done; got_err = err; rdy_at = req_rdy; done_cyc = cyc;
    @(negedge clk);
    rdy_nxt = req_rdy;
  endtask

  task automatic send_rx(input int n);
    int k;
    k = 0;
    while (txq.size() < 1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rx_vld = 1'b1;
      rx_data = rx_bytes[i];
      @(posedge clk);
      #1;
      rx_vld = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    v[0] = mk(3'd0, 32'h0, 32'h0, 1, 72'h2a, 1'b0);
    v[1] = mk(3'd1, 32'h0, 32'h0, 1, 72'h2b, 1'b0);
    v[2] = mk(3'd7, 32'h0, 32'h0, 0, 72'h0, 1'b1);
    v[3] = mk(3'd6, 32'h0, 32'h5, 0, 72'h0, 1'b1);
    v[4] = mk(3'd2, 32'h40, 32'h0, 0, 72'h0, 1'b1);
    v[5] = mk(3'd2, 32'h12345678, 32'd4, 9, 72'h2c_78563412_03000000, 1'b0);
    v[6] = mk(3'd2, 32'h00000100, 32'd12, 9, 72'h2c_00010000_0b000000, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_flags", {req_rdy, tx_vld, busy, done, err, wr_rdy, rd_vld, rx_rdy}, 8'b1000_0001);
    chk("reset_data", {tx_data, rd_data}, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (v[i]) begin
      txq.delete();
      run_req(v[i].op, v[i].addr, v[i].len);
      chk($sformatf("v%0d_done", i), got_done, 1'b1);
      chk($sformatf("v%0d_err", i), got_err, v[i].e);
      chk($sformatf("v%0d_ntx", i), txq.size(), v[i].n);
      for (int j = 0; j < v[i].n && j < txq.size(); j++)
        chk($sformatf("v%0d_tx%0d", i, j), txq[j], v[i].b[8*(v[i].n-1-j) +: 8]);
      chk($sformatf("v%0d_rdy", i), {rdy_at, rdy_nxt}, 2'b01);
    end
    // DATA_WR of 12 bytes using cfg_len=12 from the last vector
    txq.delete();
    wr_i = 0;
    wr_n = 12;
    run_req(3'd4, 32'h0, 32'h0);
    wr_n = 0;
    chk("dwr_done", {got_done, got_err}, 2'b10);
    chk("dwr_ntx", txq.size(), 13);
    chk("dwr_consumed", wr_i, 12);
    if (txq.size() == 13) begin
      chk("dwr_cmd", txq[0], 8'h2e);
      for (int j = 0; j < 12; j++) chk($sformatf("dwr_b%0d", j), txq[j+1], pay[j]);
    end
    // cfg_len := 4
    run_req(3'd2, 32'h0, 32'd4);
    chk("cfg4_done", {got_done, got_err}, 2'b10);
    // a reply byte while idle is dropped
    rdq.delete();
    @(posedge clk); #1; rx_vld = 1'b1; rx_data = 8'h55;
    @(posedge clk); #1; rx_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_rx_drop", rdq.size(), 0);
    // DATA_RD of 4 bytes
    rx_bytes[0] = 8'haa; rx_bytes[1] = 8'hbb; rx_bytes[2] = 8'hcc; rx_bytes[3] = 8'hdd;
    txq.delete();
    rdq.delete();
    fork
      run_req(3'd5, 32'h0, 32'h0);
      send_rx(4);
    join
    chk("drd_done", {got_done, got_err}, 2'b10);
    chk("drd_tx", {txq.size() == 1, txq.size() > 0 ? txq[0] : 8'h00}, {1'b1, 8'h2f});
    chk("drd_nrd", rdq.size(), 4);
    if (rdq.size() == 4) chk("drd_bytes", {rdq[0], rdq[1], rdq[2], rdq[3]}, 32'haabbccdd);
    // DATA_RD with only 2 replies times out 50 cycles after the last one
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22;
    txq.delete();
    rdq.delete();
    fork
      run_req(3'd5, 32'h0, 32'h0);
      send_rx(2);
    join
    chk("tmo_done", {got_done, got_err}, 2'b11);
    chk("tmo_nrd", rdq.size(), 2);
    if (rdq.size() == 2) chk("tmo_bytes", {rdq[0], rdq[1]}, 16'h1122);
    chk("tmo_delay", done_cyc - last_rd_cyc, 50);
    // CONF_RD always collects 8 bytes
    for (int j = 0; j < 8; j++) rx_bytes[j] = 8'(j + 1);
    txq.delete();
    rdq.delete();
    fork
      run_req(3'd3, 32'h0, 32'h0);
      send_rx(8);
    join
    chk("crd_done", {got_done, got_err}, 2'b10);
    chk("crd_cmd", txq.size() > 0 ? txq[0] : 8'h00, 8'h2d);
    chk("crd_nrd", rdq.size(), 8);
    if (rdq.size() == 8) chk("crd_last", {rdq[0], rdq[7]}, 16'h0108);
    // reset while addr byte 3 of a CONF_WR frame is on the tx port
    txq.delete();
    @(negedge clk);
    req_op = 3'd2; req_addr = 32'ha1b2c3d4; req_len = 32'd8; req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    k = 0;
    while (txq.size() < 4 && k < 500) begin @(negedge clk); #1; k++; end
    while (tx_vld && k < 500) begin @(negedge clk); #1; k++; end
    while (!tx_vld && k < 500) begin @(negedge clk); #1; k++; end
    chk("rst_wait", k < 500, 1'b1);
    chk("rst_byte3", {tx_vld, tx_data}, {1'b1, 8'ha1});
    rst_n = 1'b0;
    #1;
    chk("rst_async", {tx_vld, busy, req_rdy}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    txq.delete();
    run_req(3'd0, 32'h0, 32'h0);
    chk("post_rst_done", {got_done, got_err}, 2'b10);
    chk("post_rst_tx", {txq.size() == 1, txq.size() > 0 ? txq[0] : 8'h00}, {1'b1, 8'h2a});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_host_seq.md
Name: uart_host_seq

Overview:
- Hardware host-side command sequencer for the UART loader protocol. It sends CPU_RST/CPU_RUN/CONF_WR/CONF_RD/DATA_WR/DATA_RD frames to a target through a uart_tx byte interface.
- On CONF_RD and DATA_RD it collects the target's reply bytes from a uart_rx byte interface.
- It replaces the behavioural command table in benches and lets an on-chip master (debug bridge, self-loader) program a remote hxd32 node.

Parameters:
- XLEN, 32, width of address/length fields
- TIMEOUT, 100000, max clk_i cycles allowed between reply bytes before a read aborts

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_vld_i  in  1  request strobe
- req_rdy_o  out  1  block idle, request accepted when req_vld_i && req_rdy_o
- req_op_i  in  3  0 CPU_RST, 1 CPU_RUN, 2 CONF_WR, 3 CONF_RD, 4 DATA_WR, 5 DATA_RD
- req_addr_i  in  XLEN  CONF_WR target address
- req_len_i  in  XLEN  CONF_WR byte count (≥1)
- wr_data_i  in  8  DATA_WR payload byte
- wr_data_vld_i  in  1  payload valid
- wr_data_rdy_o  out  1  payload consumed when vld && rdy
- rd_data_o  out  8  reply byte
- rd_data_vld_o  out  1  one-cycle pulse per reply byte, no backpressure
- uart_tx_data_o  out  8  byte to uart_tx
- uart_tx_data_vld_o  out  1  byte valid
- uart_tx_data_rdy_i  in  1  uart_tx idle
- uart_rx_data_i  in  8  byte from uart_rx
- uart_rx_data_vld_i  in  1  byte valid
- uart_rx_data_rdy_o  out  1  always 1 after reset
- busy_o  out  1  transaction in progress
- done_o  out  1  one-cycle pulse at transaction end
- err_o  out  1  qualifies done_o: transaction failed

Behaviour:
- Reset values:
  - req_rdy_o=1.
  - All vld/pulse outputs, busy_o, wr_data_rdy_o and err_o = 0.
  - uart_tx_data_o = 8'h00, rd_data_o = 8'h00.
  - cfg_len register = 1.
  - uart_rx_data_rdy_o = 1.
- Command bytes: CPU_RST 2a, CPU_RUN 2b, CONF_WR 2c, CONF_RD 2d, DATA_WR 2e, DATA_RD 2f.
- TX handshake:
  - A byte transfers on the cycle uart_tx_data_vld_o && uart_tx_data_rdy_i.
  - vld_o stays high with data stable until transfer, then drops the next cycle.
  - The next byte is not presented until rdy_i is high again.
- FSM states:
  - IDLE:
    - On accept, latch op/addr/len, set busy_o, go to CMD.
    - op 6/7, or CONF_WR with len=0: no bytes sent; next cycle done_o=err_o=1, return to IDLE.
  - CMD:
    - Send the command byte.
    - Then CPU_RST/CPU_RUN go to DONE, CONF_WR to CFG, DATA_WR to WDATA, CONF_RD/DATA_RD to RDATA.
  - CFG:
    - Send 8 bytes: addr LE (byte0 first), then (len-1) LE.
    - Example: addr 0, len 12 gives 00 00 00 00 0b 00 00 00.
    - On the last byte's transfer, cfg_len := len. Go to DONE.
  - WDATA:
    - Send cfg_len bytes from the wr_data stream.
    - wr_data_rdy_o is high only while no tx byte is pending and remaining count > 0.
    - A consumed byte becomes the next uart_tx_data_o.
    - Go to DONE after the last transfer. Stalls indefinitely if wr_data_vld_i stays low (no timeout).
  - RDATA:
    - Expected count: 8 for CONF_RD, cfg_len for DATA_RD.
    - Each uart_rx_data_vld_i pulse gives rd_data_o=byte and rd_data_vld_o=1 the next cycle, then decrements the count and clears the timeout counter.
    - Count reaching 0 goes to DONE.
    - Timeout counter reaching TIMEOUT goes to DONE with err.
  - DONE: one cycle, done_o=1 (err_o as set), busy_o=0, req_rdy_o=1 next cycle.
- Counters are XLEN-bit. cfg_len=2^XLEN-1+1 wraps are not reachable because len=0 is rejected.
- Reply bytes arriving outside RDATA are discarded silently (no rd_data_vld_o).
- Simultaneous rx byte and timeout expiry: the byte wins; it is counted and the timer is cleared.
- req_vld_i while busy is ignored.
- rst_n_i asserted mid-transaction: everything returns to reset values immediately. A partially sent frame is abandoned; the target must be recovered with CPU_RST.

Test Plan:
- CPU_RST request -> exactly one tx byte 2a, done_o=1, err_o=0, req_rdy_o=1 one cycle after done.
- CONF_WR addr=0x0000_0100, len=12 -> tx 2c 00 01 00 00 0b 00 00 00 in order; cfg_len=12.
- After the above, DATA_WR with payload 93 05 00 00 6f 00 50 00 93 85 15 00, wr_data_vld_i toggled randomly -> tx 2e followed by the 12 bytes unchanged, then done_o.
- DATA_RD with cfg_len=4, responder returns aa bb cc dd -> tx 2f; four rd_data_vld_o pulses with aa,bb,cc,dd; done_o, err_o=0.
- DATA_RD where the responder returns only 2 bytes, TIMEOUT=50 -> 2 rd pulses, then done_o=err_o=1 at 50 cycles after the last byte. Also: req_op_i=7 -> no tx byte, done_o=err_o=1.
- rst_n_i pulsed low during CFG byte 3 -> uart_tx_data_vld_o=0 and busy_o=0 immediately; a subsequent CPU_RST request works normally.
